spi_slave_core: RTL and testbench



---
 rtl/spi_slave_core.sv | 152 +++++++++++++++
 tb/tb_spi_slave_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: oversampled sclk/ss_n/mosi, 32-bit MSB-first frames, one-word tx buffer.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN releases miso (1'bz) outside an active frame.
module spi_slave_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_error,
  output logic             busy
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic             r_ss_s1, r_ss_s2, r_ss_d;
  logic             r_mosi_s1, r_mosi_s2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-2:0] r_rx_shift;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_full;

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_load, w_tx_shift, w_rx_shift, w_frame_done, w_abort, w_cnt_clr, w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ss_s1   <= ss_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_ss_rise   = r_ss_s2 & ~r_ss_d;
  assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
  assign w_accept    = tx_valid & ~r_tx_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ss_n is checked first so a deselect masks any coincident sclk edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_tx_shift   = 1'b0;
    w_rx_shift   = 1'b0;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    w_cnt_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_load      = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
          w_abort     = (r_cnt != '0);
        end else if (w_sclk_rise) begin
          w_rx_shift   = 1'b1;
          w_frame_done = (r_cnt == LAST_BIT);
        end else if (w_sclk_fall) begin
          // Counter at zero on a falling edge only happens right after a completed word.
          if (r_cnt == '0) w_load = 1'b1;
          else             w_tx_shift = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= w_frame_done;
      frame_error <= w_abort;
      tx_underrun <= w_load & ~r_tx_full;

      if (w_cnt_clr)       r_cnt <= '0;
      else if (w_rx_shift) r_cnt <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;

      if (w_rx_shift) r_rx_shift <= {r_rx_shift[WIDTH-3:0], r_mosi_s2};
      if (w_frame_done) rx_data <= {r_rx_shift, r_mosi_s2};

      if (w_load)          r_tx_shift <= r_tx_full ? r_tx_buf : '0;
      else if (w_tx_shift) r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};

      // A write landing in a load cycle is kept for the following frame, never bypassed.
      if (w_accept) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  assign tx_ready = ~r_tx_full;
  assign busy     = (r_state == ST_ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (r_state == ST_ACTIVE && !r_ss_s2) ? r_tx_shift[WIDTH-1] : 1'bz;
`else
  assign miso = (r_state == ST_ACTIVE) ? r_tx_shift[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural mode-0 master at sclk = clk/10.
module tb_spi_slave_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        tx_underrun;
  logic        frame_error;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int c_rv = 0, c_un = 0, c_fe = 0, c_both = 0;
  int s_rv, s_un, s_fe;
  logic [31:0] mi, mi2;
  logic        idle_miso;

  spi_slave_core #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_error(frame_error), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)                c_rv++;
    if (tx_underrun)             c_un++;
    if (frame_error)             c_fe++;
    if (rx_valid && frame_error) c_both++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic snap();
    s_rv = c_rv;
    s_un = c_un;
    s_fe = c_fe;
  endtask

  // On the final bit of a finished frame, sclk falls and ss_n rises together.
  task automatic xfer(input logic [31:0] mo, input int nbits, input bit drop,
                      input bit fin, output logic [31:0] got);
    got = '0;
    if (drop) begin
      ss_n = 1'b0;
      tick(6);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[31-i];
      tick(5);
      sclk = 1'b1;
      got  = {got[30:0], miso};
      tick(5);
      sclk = 1'b0;
      if (fin && i == nbits - 1) ss_n = 1'b1;
    end
    if (fin) tick(8);
  endtask

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    idle_miso = 1'bz;
`else
    idle_miso = 1'b0;
`endif
    tick(4);
    chk("rst_miso",     {31'd0, miso},        {31'd0, idle_miso});
    chk("rst_tx_ready", {31'd0, tx_ready},    32'd1);
    chk("rst_rx_data",  rx_data,              32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid},    32'd0);
    chk("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    chk("rst_frm_err",  {31'd0, frame_error}, 32'd0);
    chk("rst_busy",     {31'd0, busy},        32'd0);
    reset_n = 1'b1;
    tick(4);

    // Basic frame
    push(32'hA5C3_0F96);
    chk("basic_ready_low", {31'd0, tx_ready}, 32'd0);
    snap();
    xfer(32'h1234_5678, 32, 1'b1, 1'b1, mi);
    chk("basic_miso_word", mi, 32'hA5C3_0F96);
    chk("basic_rx_data", rx_data, 32'h1234_5678);
    chk("basic_rv_cnt", c_rv - s_rv, 1);
    chk("basic_un_cnt", c_un - s_un, 0);
    chk("basic_ready_high", {31'd0, tx_ready}, 32'd1);
    chk("basic_busy_idle", {31'd0, busy}, 32'd0);
    chk("idle_miso", {31'd0, miso}, {31'd0, idle_miso});

    // Back-to-back frames with ss_n held low
    push(32'h0000_0001);
    snap();
    ss_n = 1'b0;
    tick(6);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    push(32'hFFFF_FFFF);
    xfer(32'hDEAD_BEEF, 32, 1'b0, 1'b0, mi);
    chk("b2b_rx1", rx_data, 32'hDEAD_BEEF);
    xfer(32'h0F0F_00FF, 32, 1'b0, 1'b1, mi2);
    chk("b2b_tx1", mi, 32'h0000_0001);
    chk("b2b_tx2", mi2, 32'hFFFF_FFFF);
    chk("b2b_rx2", rx_data, 32'h0F0F_00FF);
    chk("b2b_rv_cnt", c_rv - s_rv, 2);
    chk("b2b_un_cnt", c_un - s_un, 0);

    // Underrun: buffer empty at frame start
    snap();
    xfer(32'h5A5A_C3C3, 32, 1'b1, 1'b1, mi);
    chk("un_miso_zero", mi, 32'h0);
    chk("un_cnt", c_un - s_un, 1);
    chk("un_rx_data", rx_data, 32'h5A5A_C3C3);
    chk("un_rv_cnt", c_rv - s_rv, 1);

    // Mid-frame abort after 17 bits
    push(32'h1357_9BDF);
    snap();
    xfer(32'hCAFE_F00D, 17, 1'b1, 1'b1, mi);
    chk("abort_partial_tx", mi, 32'h1357_9BDF >> 15);
    chk("abort_fe_cnt", c_fe - s_fe, 1);
    chk("abort_rv_cnt", c_rv - s_rv, 0);
    chk("abort_rx_hold", rx_data, 32'h5A5A_C3C3);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    push(32'h2468_ACE0);
    snap();
    xfer(32'h8765_4321, 32, 1'b1, 1'b1, mi);
    chk("after_abort_tx", mi, 32'h2468_ACE0);
    chk("after_abort_rx", rx_data, 32'h8765_4321);
    chk("after_abort_rv", c_rv - s_rv, 1);
    chk("after_abort_fe", c_fe - s_fe, 0);

    // Reset mid-frame after 9 bits
    push(32'h1111_1111);
    snap();
    xfer(32'hF0F0_F0F0, 9, 1'b1, 1'b0, mi);
    chk("rmf_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #3;
    chk("rmf_rx_data", rx_data, 32'h0);
    chk("rmf_ready", {31'd0, tx_ready}, 32'd1);
    chk("rmf_busy", {31'd0, busy}, 32'd0);
    chk("rmf_miso", {31'd0, miso}, {31'd0, idle_miso});
    ss_n = 1'b1;
    sclk = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(8);
    chk("rmf_no_rv", c_rv - s_rv, 0);
    chk("rmf_no_un", c_un - s_un, 0);
    chk("rmf_no_fe", c_fe - s_fe, 0);
    push(32'h0BAD_F00D);
    xfer(32'h600D_CAFE, 32, 1'b1, 1'b1, mi);
    chk("rmf_next_tx", mi, 32'h0BAD_F00D);
    chk("rmf_next_rx", rx_data, 32'h600D_CAFE);

    chk("never_rv_and_fe", c_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
